// File: rtl/memlcd_pkg.sv
// Shared definitions for the memory-LCD write engine: stream field widths,
// mode-bit positions within the mode field, and the frame FSM state encoding.
`timescale 1ns/1ps
package memlcd_pkg;

    localparam int unsigned MODE_W  = 6;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DUMMY_W = 16;

    // Position of each mode flag within the MSB-first mode field
    localparam int unsigned MODE_M0 = 0;
    localparam int unsigned MODE_M1 = 1;
    localparam int unsigned MODE_M2 = 2;

    typedef enum logic [3:0] {
        ST_IDLE_WAIT,
        ST_SETUP,
        ST_MODE,
        ST_ADDR,
        ST_DATA,
        ST_DUMMY,
        ST_TRAIL,
        ST_HOLD,
        ST_DONE
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/memlcd_spi_shifter.sv
// Serial clock generator and single-bit shift stage: latches a presented bit while
// sclk is low, clocks it out with one sclk pulse, and strobes when it takes a bit.
`timescale 1ns/1ps
module memlcd_spi_shifter #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    input  logic i_bit,
    output logic o_sclk,
    output logic o_si,
    output logic o_busy,
    output logic o_accept_c
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             r_sclk;
    logic             r_si;
    logic             r_busy;
    logic             w_div_done;
    logic             w_fall;

    assign w_div_done = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_fall     = r_busy && r_sclk && w_div_done;
    // A new bit is taken when idle or on the falling edge of the current bit
    assign o_accept_c = i_valid && (!r_busy || w_fall);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
            r_si   <= 1'b0;
            r_busy <= 1'b0;
        end else if (o_accept_c) begin
            r_si   <= i_bit;
            r_busy <= 1'b1;
            r_sclk <= 1'b0;
            r_div  <= '0;
        end else if (r_busy) begin
            if (w_div_done) begin
                r_div <= '0;
                if (r_sclk) begin
                    r_sclk <= 1'b0;
                    r_busy <= 1'b0;
                    r_si   <= 1'b0;
                end else begin
                    r_sclk <= 1'b1;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign o_sclk = r_sclk;
    assign o_si   = r_si;
    assign o_busy = r_busy;

endmodule

// File: rtl/memlcd_top.sv
// Self-running memory-LCD write engine: after reset, streams a checkerboard frame over sclk/si/scs.
// Define MEMLCD_REPEAT_EN to send frames continuously with VCOM toggling every frame.
`timescale 1ns/1ps
module memlcd_top
    import memlcd_pkg::*;
#(
    parameter int unsigned H_PIXELS    = 336,
    parameter int unsigned LINES       = 8,
    parameter int unsigned CLK_DIV     = 1,
    parameter int unsigned SCS_SETUP   = 4,
    parameter int unsigned SCS_HOLD    = 4,
    parameter int unsigned START_DELAY = 16
) (
    input  logic        refclk,
    input  logic        rst,
    output logic        lcd_sclk,
    output logic        lcd_si,
    output logic        lcd_scs,
    output logic        sim_success,
    output logic [15:0] sim_report
);

    // SETUP is shortened by the shifter's load cycle and low phase so the first
    // sclk rise lands SCS_SETUP cycles after scs; HOLD absorbs the idle-detect cycle.
    localparam int unsigned SETUP_LEN = SCS_SETUP - CLK_DIV - 1;
    localparam int unsigned HOLD_LEN  = SCS_HOLD - 1;
    localparam int unsigned CNT_W     = $clog2(max_u(max_u(START_DELAY, SETUP_LEN), HOLD_LEN) + 1);
    localparam int unsigned BIT_W     = $clog2(max_u(max_u(H_PIXELS, DUMMY_W), ADDR_W) + 1);
    localparam int unsigned LINE_W    = $clog2(LINES + 1);
    localparam int unsigned AIDX_W    = $clog2(ADDR_W);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [BIT_W-1:0]    r_bit;
    logic [LINE_W-1:0]   r_line;
    logic                r_vcom;
    logic                r_scs;
    logic                r_success;
    logic [15:0]         r_report;

    logic                w_valid;
    logic                w_bit;
    logic                w_accept;
    logic                w_busy;
    logic                w_sclk;
    logic                w_si;
    logic [ADDR_W-1:0]   w_addr;

    assign w_addr  = ADDR_W'(r_line);
    assign w_valid = (r_state == ST_MODE) || (r_state == ST_ADDR) || (r_state == ST_DATA) ||
                     (r_state == ST_DUMMY) ||
                     ((r_state == ST_TRAIL) && (r_bit < BIT_W'(DUMMY_W)));

    // Bit currently pointed to by the field/bit counters
    always_comb begin
        w_bit = 1'b0;
        case (r_state)
            ST_MODE: begin
                if (r_bit == BIT_W'(MODE_M0))      w_bit = 1'b1;
                else if (r_bit == BIT_W'(MODE_M1)) w_bit = r_vcom;
                else if (r_bit == BIT_W'(MODE_M2)) w_bit = 1'b0;
            end
            ST_ADDR: w_bit = w_addr[AIDX_W'(ADDR_W - 1) - r_bit[AIDX_W-1:0]];
            ST_DATA: w_bit = r_bit[0] ^ r_line[0];
            default: w_bit = 1'b0;
        endcase
    end

    memlcd_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .i_clk      (refclk),
        .i_rst_n    (rst),
        .i_valid    (w_valid),
        .i_bit      (w_bit),
        .o_sclk     (w_sclk),
        .o_si       (w_si),
        .o_busy     (w_busy),
        .o_accept_c (w_accept)
    );

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE_WAIT;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_line    <= '0;
            r_vcom    <= 1'b0;
            r_scs     <= 1'b0;
            r_success <= 1'b0;
            r_report  <= '0;
        end else begin
            case (r_state)
                ST_IDLE_WAIT: begin
                    if (r_cnt == CNT_W'(START_DELAY - 1)) begin
                        r_state <= ST_SETUP;
                        r_cnt   <= '0;
                        r_scs   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == CNT_W'(SETUP_LEN - 1)) begin
                        r_state <= ST_MODE;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_line  <= LINE_W'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_MODE: begin
                    if (w_accept) begin
                        if (r_bit == BIT_W'(MODE_W - 1)) begin
                            r_state <= ST_ADDR;
                            r_bit   <= '0;
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_accept) begin
                        if (r_bit == BIT_W'(ADDR_W - 1)) begin
                            r_state <= ST_DATA;
                            r_bit   <= '0;
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        if (r_bit == BIT_W'(H_PIXELS - 1)) begin
                            r_state <= ST_DUMMY;
                            r_bit   <= '0;
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end
                end
                ST_DUMMY: begin
                    if (w_accept) begin
                        if (r_bit == BIT_W'(DUMMY_W - 1)) begin
                            r_bit    <= '0;
                            r_report <= r_report + 16'd1;
                            if (r_line == LINE_W'(LINES)) begin
                                r_state <= ST_TRAIL;
                            end else begin
                                r_state <= ST_ADDR;
                                r_line  <= r_line + LINE_W'(1);
                            end
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end
                end
                ST_TRAIL: begin
                    // Wait for the last trailing bit to finish clocking out
                    if (w_accept) begin
                        r_bit <= r_bit + BIT_W'(1);
                    end else if ((r_bit == BIT_W'(DUMMY_W)) && !w_busy) begin
                        r_state <= ST_HOLD;
                        r_bit   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == CNT_W'(HOLD_LEN - 1)) begin
                        r_scs     <= 1'b0;
                        r_success <= 1'b1;
                        r_cnt     <= '0;
`ifdef MEMLCD_REPEAT_EN
                        r_state   <= ST_IDLE_WAIT;
                        r_vcom    <= ~r_vcom;
`else
                        r_state   <= ST_DONE;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE_WAIT;
                end
            endcase
        end
    end

    assign lcd_sclk    = w_sclk;
    assign lcd_si      = w_si;
    assign lcd_scs     = r_scs;
    assign sim_success = r_success;
    assign sim_report  = r_report;

endmodule

// File: tb/tb_memlcd_top.sv
// Self-checking bench for memlcd_top: decodes si on sclk rises against a queued
// frame model, then checks timing, field table, idle behaviour and mid-frame reset.
`timescale 1ns/1ps
module tb_memlcd_top;

    localparam int H_PIXELS    = 336;
    localparam int LINES       = 8;
    localparam int CLK_DIV     = 1;
    localparam int SCS_SETUP   = 4;
    localparam int SCS_HOLD    = 4;
    localparam int START_DELAY = 16;
    localparam int ADDR_W      = 10;
    localparam int LINE_BITS   = ADDR_W + H_PIXELS + 16;
    localparam int FRAME_BITS  = 6 + LINES * LINE_BITS + 16;
    localparam int EXP_FALL    = START_DELAY + SCS_SETUP + 2 * CLK_DIV * (FRAME_BITS - 1) + CLK_DIV + SCS_HOLD;

    logic        refclk = 1'b0;
    logic        rst    = 1'b0;
    logic        lcd_sclk, lcd_si, lcd_scs, sim_success;
    logic [15:0] sim_report;

    memlcd_top u_dut (
        .refclk      (refclk),
        .rst         (rst),
        .lcd_sclk    (lcd_sclk),
        .lcd_si      (lcd_si),
        .lcd_scs     (lcd_scs),
        .sim_success (sim_success),
        .sim_report  (sim_report)
    );

    always #41.667 refclk = ~refclk;

    typedef struct {
        string name;
        int    off;
        int    len;
        int    exp;
    } fld_t;

    int          checks = 0;
    int          errors = 0;
    bit          exp_q[$];
    bit          cap [0:2*FRAME_BITS-1];
    int          n_rise = 0;
    int          si_viol = 0;
    int          sclk_viol = 0;
    bit          mon_en = 1'b0;
    logic        prev_sclk = 1'b0;
    logic        prev_si = 1'b0;
    logic [15:0] prev_rep = '0;
    bit          e;
    fld_t        tbl[11];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void push_frame(input bit vcom);
        exp_q.push_back(1'b1);
        exp_q.push_back(vcom);
        for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
        for (int y = 1; y <= LINES; y++) begin
            for (int b = ADDR_W - 1; b >= 0; b--) exp_q.push_back(1'((y >> b) & 1));
            for (int x = 0; x < H_PIXELS; x++) exp_q.push_back(1'((x ^ y) & 1));
            for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
        end
        for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
    endfunction

    function automatic int field(input int off, input int len);
        int v = 0;
        for (int i = 0; i < len; i++) v = (v << 1) | int'(cap[off + i]);
        return v;
    endfunction

    // Decode si on every sclk rise and score it against the queued model
    always @(negedge refclk) begin
        if (mon_en && rst) begin
            if (lcd_sclk && !prev_sclk) begin
                if (!lcd_scs) sclk_viol++;
                if (n_rise < 2 * FRAME_BITS) cap[n_rise] = lcd_si;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_extra_bit index %0d got si=%b expected no bit", n_rise, lcd_si);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("stream_bit_%0d", n_rise), int'(lcd_si), int'(e));
                end
                n_rise++;
            end
            if ((lcd_si != prev_si) && lcd_sclk) si_viol++;
            if (sim_report != prev_rep) check("report_step", int'(sim_report), int'(prev_rep + 16'd1));
        end
        prev_sclk = lcd_sclk;
        prev_si   = lcd_si;
        prev_rep  = sim_report;
    end

    task automatic run_frame(input int nframes);
        int cyc     = 0;
        int t_scs   = -1;
        int t_sclk  = -1;
        int t_fall  = -1;
        int last_hi = -1;
        exp_q.delete();
        n_rise    = 0;
        si_viol   = 0;
        sclk_viol = 0;
        for (int f = 0; f < nframes; f++) push_frame(1'(f & 1));
        @(negedge refclk);
        rst    = 1'b1;
        mon_en = 1'b1;
        while (t_fall < 0 && cyc < 8000) begin
            @(posedge refclk);
            #1;
            cyc++;
            if (lcd_scs && t_scs < 0) t_scs = cyc;
            if (lcd_sclk && t_sclk < 0) t_sclk = cyc;
            if (lcd_sclk) last_hi = cyc;
            if (!lcd_scs && t_scs >= 0) t_fall = cyc;
        end
        check("scs_rise_cycle", t_scs, START_DELAY);
        check("first_sclk_cycle", t_sclk, START_DELAY + SCS_SETUP);
        check("scs_fall_cycle", t_fall, EXP_FALL);
        check("scs_hold_cycles", t_fall - (last_hi + 1), SCS_HOLD);
        check("sclk_rises_in_frame", n_rise, FRAME_BITS);
        check("sim_report_end", int'(sim_report), LINES);
        check("sim_success_set", int'(sim_success), 1);
        check("si_stable_at_rise", si_viol, 0);
        check("sclk_outside_scs", sclk_viol, 0);
        for (int i = 0; i < 11; i++) check(tbl[i].name, field(tbl[i].off, tbl[i].len), tbl[i].exp);
    endtask

`ifdef MEMLCD_REPEAT_EN
    task automatic second_window();
        int cyc = 0;
        int t_r = -1;
        int t_f = -1;
        while (t_f < 0 && cyc < 8000) begin
            @(posedge refclk);
            #1;
            cyc++;
            if (lcd_scs && t_r < 0) t_r = cyc;
            if (!lcd_scs && t_r >= 0) t_f = cyc;
        end
        check("frame2_done", int'(t_f >= 0), 1);
        check("frame2_report", int'(sim_report), 2 * LINES);
        check("frame2_rises", n_rise, 2 * FRAME_BITS);
        check("frame2_mode", field(FRAME_BITS, 6), 'h30);
        check("frame2_success", int'(sim_success), 1);
        mon_en = 1'b0;
    endtask
`endif

    initial begin
        int mid_rises;
        int bad;
        int rises0;
        tbl[0]  = '{"mode_field",     0,                        6,  'h20};
        tbl[1]  = '{"addr_line1",     6,                        10, 1};
        tbl[2]  = '{"line1_head",     16,                       16, 'hAAAA};
        tbl[3]  = '{"line1_tail",     16 + H_PIXELS - 16,       16, 'hAAAA};
        tbl[4]  = '{"dummy_line1",    16 + H_PIXELS,            16, 0};
        tbl[5]  = '{"addr_line2",     6 + LINE_BITS,            10, 2};
        tbl[6]  = '{"line2_head",     16 + LINE_BITS,           16, 'h5555};
        tbl[7]  = '{"addr_line8",     6 + 7 * LINE_BITS,        10, 8};
        tbl[8]  = '{"line8_head",     16 + 7 * LINE_BITS,       16, 'h5555};
        tbl[9]  = '{"dummy_line8",    16 + 7 * LINE_BITS + H_PIXELS, 16, 0};
        tbl[10] = '{"trailer",        FRAME_BITS - 16,          16, 0};

        rst = 1'b0;
        repeat (12) @(posedge refclk);
        @(negedge refclk);
        check("reset_ctrl_outputs", int'({lcd_sclk, lcd_si, lcd_scs, sim_success}), 0);
        check("reset_report", int'(sim_report), 0);

`ifdef MEMLCD_REPEAT_EN
        run_frame(2);
        second_window();
`else
        run_frame(1);
        rises0 = n_rise;
        bad    = 0;
        while ($time < 800000) begin
            @(posedge refclk);
            #1;
            if (lcd_sclk || lcd_si || lcd_scs || !sim_success) bad++;
        end
        check("idle_after_done", bad, 0);
        check("no_rises_after_done", n_rise - rises0, 0);
        check("report_held", int'(sim_report), LINES);
`endif

        // Mid-frame reset: abort during data, then the frame restarts cleanly
        mon_en = 1'b0;
        rst    = 1'b0;
        repeat (12) @(posedge refclk);
        exp_q.delete();
        push_frame(1'b0);
        n_rise = 0;
        @(negedge refclk);
        rst    = 1'b1;
        mon_en = 1'b1;
        repeat (2400) @(posedge refclk);
        mid_rises = n_rise;
        #20;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check("midreset_ctrl_outputs", int'({lcd_sclk, lcd_si, lcd_scs, sim_success}), 0);
        check("midreset_report", int'(sim_report), 0);
        check("midframe_progress", int'(mid_rises > 1000 && mid_rises < 2000), 1);
        repeat (12) @(posedge refclk);
`ifdef MEMLCD_REPEAT_EN
        run_frame(2);
        mon_en = 1'b0;
`else
        run_frame(1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memlcd_top.md
Name:
memlcd_top

Overview:
Self-running Sharp-style memory-LCD write engine that pushes one test frame over the 3-wire LCD SPI (sclk/si/scs) after reset. It is the simulation top for the memory-LCD controller: runs from the 12 MHz reference clock and flags completion on `sim_success` and `sim_report` for CI.

Parameters:
- H_PIXELS, 336: data bits per line.
- LINES, 8: lines written per frame; addresses 1..LINES.
- CLK_DIV, 1: sclk half-period in refclk cycles.
- SCS_SETUP, 4: refclk cycles from scs rise to first sclk rise.
- SCS_HOLD, 4: refclk cycles from last sclk fall to scs fall.
- START_DELAY, 16: refclk cycles after reset release before the frame starts.

Ports:
- refclk, input, 1: 12 MHz system clock.
- rst, input, 1: asynchronous, active-low reset.
- lcd_sclk, output, 1: LCD serial clock; idle low.
- lcd_si, output, 1: LCD serial data.
- lcd_scs, output, 1: LCD chip select, active-high.
- sim_success, output, 1: sticky frame-complete flag.
- sim_report, output, 16: count of completed lines.

Behaviour:
- Reset (`rst`=0, asynchronous): all outputs 0; counters and FSM cleared. Reset mid-frame aborts immediately; the frame restarts from scratch START_DELAY cycles after release.
- FSM states and transitions:
  - IDLE_WAIT → SETUP: after START_DELAY.
  - SETUP → MODE: scs=1, hold for SCS_SETUP cycles.
  - MODE → ADDR → DATA → DUMMY: per line.
  - DUMMY → ADDR (next line) or TRAIL (after line LINES).
  - TRAIL → HOLD → DONE.
- Stream format, one scs window, MSB first, all fields serial:
  - Mode: 6 bits. M0=1 (update), M1=VCOM (0 in first frame), M2..M5=0, so "100000".
  - Per line: 10-bit address (line number, 1-based), then H_PIXELS data bits, then 16 dummy zeros.
  - After the last line: 16 trailing dummy zeros.
- Pixel bit for line y (1-based), pixel x (0-based) = (x ^ y) & 1. Line 1 therefore starts 1,0,1,0…
- SPI timing:
  - si changes only while sclk is low (on the sclk fall, or at state entry); stable around the sclk rise.
  - sclk toggles every CLK_DIV refclk cycles, only while shifting.
  - sclk is low in SETUP, HOLD, DONE and IDLE_WAIT.
- `sim_report` increments by 1 at the end of each line's dummy field; final value LINES.
- `sim_success` is set when HOLD completes (scs has fallen) and stays set until reset.
- DONE: outputs idle (scs=0, sclk=0, si=0); no further traffic.
- Defaults give 2918 bits, about 5850 refclk cycles (about 490 µs), well within an 800 µs run.
- All counters are sized to hold their maximum parameter value. Bit counters wrap to 0 at field boundaries. No other wrap conditions exist.

Optional Feature:
`MEMLCD_REPEAT_EN`.
- Defined: after HOLD the FSM returns to IDLE_WAIT and sends frames indefinitely.
  - M1 (VCOM) toggles every frame.
  - `sim_report` keeps counting lines (wraps at 16 bits).
  - `sim_success` is still set after the first frame.
- Undefined: single frame, then DONE forever.

Decomposition:
- memlcd_pkg: mode bit positions (M0 update, M1 VCOM, M2 clear), field widths (MODE_W=6, ADDR_W=10, DUMMY_W=16), FSM state enum.
- One sub-module memlcd_spi_shifter: clock divider plus a shift-out of a presented bit, with a bit-accepted strobe. The top FSM only supplies the next bit and field lengths.

Test Plan:
- Reset held low 1 µs, then released: all outputs 0 during reset. scs rises 16 cycles after release; first sclk rise 4 cycles later.
- Decode si on sclk rises: first 16 bits = 100000 0000000001 (mode, then address 1). Line 1 data = 336 alternating bits starting 1. Then 16 zeros.
- Full frame: 8 addresses 1..8 in order, each followed by the checkerboard data. 2918 total sclk rises in one scs window. `sim_report` steps 0→8.
- `sim_success` rises after scs falls (before 500 µs) and stays 1. No sclk/si activity afterwards through 800 µs.
- Assert reset at 200 µs mid-data: outputs 0 instantly, `sim_report`=0. After release the frame restarts from the mode field and completes normally.
- With `MEMLCD_REPEAT_EN` defined: the second scs window's mode field = 110000 (VCOM=1). `sim_report` reaches 16 after two frames.
